// File: rtl/uart_tx_module.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period.
// Timing is driven by a 16x-baud s_tick enable. tx and tx_busy are registered.
module uart_tx_module #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned PARITY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam int unsigned TW = 5;
    localparam int unsigned BW = 3;
    localparam int unsigned DW = 8;
    localparam logic [DW-1:0] DMASK = DW'((16'd1 << DBIT) - 16'd1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] s_reg, s_next;
    logic [BW-1:0] n_reg, n_next;
    logic [DW-1:0] b_reg, b_next;
    logic          p_reg, p_next;
    logic          tx_reg, tx_next;
    logic          busy_reg;
    logic [DW-1:0] din_m;

    assign din_m   = din & DMASK;
    assign tx      = tx_reg;
    assign tx_busy = busy_reg;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            s_reg    <= '0;
            n_reg    <= '0;
            b_reg    <= '0;
            p_reg    <= 1'b0;
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
        end else begin
            state    <= state_next;
            s_reg    <= s_next;
            n_reg    <= n_next;
            b_reg    <= b_next;
            p_reg    <= p_next;
            tx_reg   <= tx_next;
            busy_reg <= (state_next != IDLE);
        end
    end

    // Next-state, datapath update and end-of-frame pulse
    always_comb begin
        state_next   = state;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        p_next       = p_reg;
        tx_next      = tx_reg;
        tx_done_tick = 1'b0;
        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    n_next     = '0;
                    b_next     = din_m;
                    p_next     = (PARITY == 2) ? ~(^din_m) : ^din_m;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (s_tick) begin
                    if (s_reg == TW'(15)) begin
                        s_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + TW'(1);
                    end
                end
            end
            DATA: begin
                tx_next = b_reg[0];
                if (s_tick) begin
                    if (s_reg == TW'(15)) begin
                        s_next = '0;
                        b_next = {1'b0, b_reg[DW-1:1]};
                        if (n_reg == BW'(DBIT - 1)) begin
                            state_next = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            n_next = n_reg + BW'(1);
                        end
                    end else begin
                        s_next = s_reg + TW'(1);
                    end
                end
            end
            PAR: begin
                tx_next = p_reg;
                if (s_tick) begin
                    if (s_reg == TW'(15)) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + TW'(1);
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (s_tick) begin
                    if (s_reg == TW'(SB_TICK - 1)) begin
                        tx_done_tick = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        s_next = s_reg + TW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
